// File: rtl/vram_slot_arbiter.sv
// Time-slots one synchronous VRAM port between video scanout and a CPU write FIFO / read path.
// Optional stall statistics counter enabled by defining ARB_STATS_EN.
module vram_slot_arbiter #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_vid,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [7:0]        cpu_wr_data,
  output logic              fifo_full,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_busy,
  output logic              cpu_rd_valid,
  output logic [7:0]        cpu_rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
`ifdef ARB_STATS_EN
  ,
  input  logic              stall_clr,
  output logic [15:0]       stall_count
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_VID = 2'd1, TAG_RD = 2'd2} tag_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_entry_t;

  wr_entry_t         fifo_q [FIFO_DEPTH];
  wr_entry_t         fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, snap_q, snap_d;
  logic              full_q, full_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [7:0]        vid_data_q, vid_data_d;
  tag_e              tag_q, tag_d;
`ifdef ARB_STATS_EN
  logic [15:0]       stall_q, stall_d;
`endif

  wr_entry_t head_c;
  logic      slot_rd_c, slot_wr_c, push_c, pop_c, capture_c;

  // Slot decision: video first, then a read whose ordering writes have drained, then writes.
  always_comb begin
    head_c    = fifo_q[rd_ptr_q];
    slot_rd_c = !ce_pix && rd_pend_q && (snap_q == '0);
    slot_wr_c = !ce_pix && !slot_rd_c && (count_q != '0);
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (ce_pix) begin
      ram_addr = vid_addr;
    end else if (slot_rd_c) begin
      ram_addr = rd_addr_q;
    end else if (slot_wr_c) begin
      ram_addr  = head_c.addr;
      ram_wdata = head_c.data;
      ram_we    = reset_n;
    end
  end

  always_comb begin
    push_c     = cpu_wr_req && !full_q;
    pop_c      = slot_wr_c;
    capture_c  = cpu_rd_req && !busy_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    snap_d     = snap_q;
    vid_data_d = vid_data_q;
    rd_data_d  = rd_data_q;
    if (push_c) begin
      fifo_d[wr_ptr_q] = '{addr: cpu_wr_addr, data: cpu_wr_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    // Snapshot counts only writes queued up to and including this cycle.
    if (capture_c) begin
      rd_pend_d = 1'b1;
      rd_addr_d = cpu_rd_addr;
      snap_d    = count_d;
    end else if (rd_pend_q) begin
      if (slot_rd_c)  rd_pend_d = 1'b0;
      else if (pop_c) snap_d    = snap_q - CNT_W'(1);
    end
    tag_d = ce_pix ? TAG_VID : (slot_rd_c ? TAG_RD : TAG_NONE);
    if (tag_q == TAG_VID) vid_data_d = ram_rdata;
    if (tag_q == TAG_RD)  rd_data_d  = ram_rdata;
    valid_d = (tag_q == TAG_RD);
    busy_d  = (busy_q && (tag_q != TAG_RD)) || capture_c;
`ifdef ARB_STATS_EN
    stall_d = stall_q;
    if (stall_clr) stall_d = '0;
    else if (((cpu_wr_req && full_q) || (rd_pend_q && !slot_rd_c)) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
`endif
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      snap_q     <= '0;
      full_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      rd_data_q  <= '0;
      vid_data_q <= '0;
      tag_q      <= TAG_NONE;
`ifdef ARB_STATS_EN
      stall_q    <= '0;
`endif
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      snap_q     <= snap_d;
      full_q     <= full_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      rd_data_q  <= rd_data_d;
      vid_data_q <= vid_data_d;
      tag_q      <= tag_d;
`ifdef ARB_STATS_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign vid_data     = vid_data_q;
  assign fifo_full    = full_q;
  assign cpu_rd_busy  = busy_q;
  assign cpu_rd_valid = valid_q;
  assign cpu_rd_data  = rd_data_q;
`ifdef ARB_STATS_EN
  assign stall_count  = stall_q;
`endif

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Self-checking bench for vram_slot_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
module tb_vram_slot_arbiter;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DEPTH  = 4;
  localparam int K_IDLE = 0, K_VID = 1, K_WR = 2, K_RD = 3;

  typedef struct packed { logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;

  logic              clk_vid = 1'b0;
  logic              reset_n, ce_pix, cpu_wr_req, cpu_rd_req;
  logic [ADDR_W-1:0] vid_addr, cpu_wr_addr, cpu_rd_addr, ram_addr;
  logic [7:0]        vid_data, cpu_wr_data, cpu_rd_data, ram_wdata, ram_rdata;
  logic              fifo_full, cpu_rd_busy, cpu_rd_valid, ram_we;
`ifdef ARB_STATS_EN
  logic              stall_clr;
  logic [15:0]       stall_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vram_slot_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .vid_addr(vid_addr),
    .vid_data(vid_data), .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_data(cpu_wr_data), .fifo_full(fifo_full), .cpu_rd_req(cpu_rd_req),
    .cpu_rd_addr(cpu_rd_addr), .cpu_rd_busy(cpu_rd_busy), .cpu_rd_valid(cpu_rd_valid),
    .cpu_rd_data(cpu_rd_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_STATS_EN
    , .stall_clr(stall_clr), .stall_count(stall_count)
`endif
  );

  always #5 clk_vid = ~clk_vid;

  function automatic logic [7:0] ram_init(input int i);
    logic [15:0] a;
    a = 16'(i);
    return (a == 16'h2000) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  // Synchronous RAM environment: read-first, one cycle read latency.
  logic [7:0] tb_mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) tb_mem[i] = ram_init(i);
    forever begin
      @(posedge clk_vid);
      if (ram_we) tb_mem[ram_addr[15:0]] <= ram_wdata;
      ram_rdata <= tb_mem[ram_addr[15:0]];
    end
  end

  // Reference model state
  logic [7:0]        m_mem [0:65535];
  wr_t               m_wq [$];
  bit                m_rd_pend;
  logic [ADDR_W-1:0] m_rd_addr;
  int                m_rd_ahead;
  int                p_kind;
  logic [7:0]        p_data;
  int                e_kind;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_wdata, e_vid, e_rd_data;
  bit                e_full, e_busy, e_valid;
  logic [15:0]       e_stall;

  task automatic reset_model();
    m_wq.delete();
    m_rd_pend = 0; m_rd_ahead = 0; m_rd_addr = '0;
    p_kind = K_IDLE; p_data = '0;
    e_vid = '0; e_rd_data = '0; e_full = 0; e_busy = 0; e_valid = 0; e_stall = '0;
  endtask

  task automatic model_slot();
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (ce_pix) begin
      e_kind = K_VID; e_addr = vid_addr;
    end else if (m_rd_pend && m_rd_ahead == 0) begin
      e_kind = K_RD; e_addr = m_rd_addr;
    end else if (m_wq.size() > 0) begin
      e_kind = K_WR; e_addr = m_wq[0].a; e_wdata = m_wq[0].d; e_we = 1'b1;
    end else begin
      e_kind = K_IDLE;
    end
  endtask

  task automatic model_advance();
    bit         old_busy;
    int         nk;
    logic [7:0] nd;
    old_busy = e_busy;
`ifdef ARB_STATS_EN
    if (stall_clr) e_stall = '0;
    else if (((cpu_wr_req && e_full) || (m_rd_pend && e_kind != K_RD)) && e_stall != 16'hFFFF)
      e_stall = e_stall + 16'd1;
`endif
    e_valid = (p_kind == K_RD);
    if (p_kind == K_VID) e_vid = p_data;
    if (p_kind == K_RD) begin e_rd_data = p_data; e_busy = 0; end
    nk = K_IDLE; nd = '0;
    case (e_kind)
      K_VID: begin nk = K_VID; nd = m_mem[vid_addr[15:0]]; end
      K_RD:  begin nk = K_RD; nd = m_mem[m_rd_addr[15:0]]; m_rd_pend = 0; end
      K_WR: begin
        m_mem[m_wq[0].a[15:0]] = m_wq[0].d;
        void'(m_wq.pop_front());
        if (m_rd_pend) m_rd_ahead--;
      end
      default: ;
    endcase
    if (cpu_wr_req && !e_full) m_wq.push_back(wr_t'{a: cpu_wr_addr, d: cpu_wr_data});
    if (cpu_rd_req && !old_busy) begin
      m_rd_pend = 1; m_rd_addr = cpu_rd_addr; m_rd_ahead = m_wq.size(); e_busy = 1;
    end
    e_full = (m_wq.size() == int'(DEPTH));
    p_kind = nk; p_data = nd;
  endtask

  task automatic set_idle();
    ce_pix = 0; cpu_wr_req = 0; cpu_rd_req = 0;
    vid_addr = '0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_rd_addr = '0;
`ifdef ARB_STATS_EN
    stall_clr = 0;
`endif
  endtask

  task automatic settle();
    #1;
    model_slot();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk_vid);
    @(negedge clk_vid);
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 0; set_idle();
    cpu_wr_req = 1; cpu_wr_addr = 23'h0123; cpu_wr_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_vid); @(negedge clk_vid); #1;
      total++;
      if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", ram_we); end
      total++;
      if ({vid_data, fifo_full, cpu_rd_busy, cpu_rd_valid, cpu_rd_data} !== 19'h0) begin
        bad++; $display("FAIL reset_regs vid=%h full=%b busy=%b valid=%b rd=%h want all 0",
                        vid_data, fifo_full, cpu_rd_busy, cpu_rd_valid, cpu_rd_data);
      end
    end
    reset_n = 1; set_idle(); reset_model();
  endtask

  task automatic test_video();
    vid_addr = 23'h12000;
    for (int i = 0; i < 6; i++) begin
      ce_pix = (i % 2 == 0);
      settle();
      if (ce_pix) begin
        total++;
        if (ram_addr !== 23'h12000 || ram_we !== 1'b0) begin
          bad++; $display("FAIL video_slot addr=%h we=%b want 12000/0", ram_addr, ram_we);
        end
      end
      advance();
      total++;
      if (vid_data !== ((i == 0) ? 8'h00 : 8'hA5)) begin
        bad++; $display("FAIL video_data step=%0d got=%h want=%h", i, vid_data,
                        (i == 0) ? 8'h00 : 8'hA5);
      end
    end
    set_idle();
  endtask

  task automatic test_write_burst();
    ce_pix = 1; vid_addr = 23'h12000;
    for (int i = 0; i < 5; i++) begin
      cpu_wr_req = 1; cpu_wr_addr = 23'h0400 + ADDR_W'(i); cpu_wr_data = 8'(i + 1);
      settle(); advance();
      total++;
      if (fifo_full !== (i >= 3) || fifo_full !== e_full) begin
        bad++; $display("FAIL burst_full push=%0d got=%b want=%b", i, fifo_full, i >= 3);
      end
    end
    cpu_wr_req = 0; ce_pix = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if (ram_we !== 1'b1 || ram_addr !== 23'h0400 + ADDR_W'(i) || ram_wdata !== 8'(i + 1)) begin
        bad++; $display("FAIL burst_wr slot=%0d we=%b addr=%h data=%h want 1/%h/%h", i, ram_we,
                        ram_addr, ram_wdata, 23'h0400 + ADDR_W'(i), 8'(i + 1));
      end
      advance();
    end
    settle();
    total++;
    if (fifo_full !== 1'b0 || ram_we !== 1'b0) begin
      bad++; $display("FAIL burst_drain full=%b we=%b want 0/0 (5th write refused)",
                      fifo_full, ram_we);
    end
    advance();
  endtask

  task automatic test_write_then_read();
    int wr_slot = -1, rd_slot = -1, v_cyc = -1, nv = 0;
    logic [7:0] v_data = '0;
    ce_pix = 1; cpu_wr_req = 1; cpu_wr_addr = 23'h0400; cpu_wr_data = 8'h5A;
    settle(); advance();
    cpu_wr_req = 0; cpu_rd_req = 1; cpu_rd_addr = 23'h0400;
    settle(); advance();
    cpu_rd_req = 0; ce_pix = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (ram_we && ram_addr == 23'h0400 && wr_slot < 0) wr_slot = cyc;
      if (!ram_we && ram_addr == 23'h0400 && rd_slot < 0) rd_slot = cyc;
      advance();
      if (cpu_rd_valid) begin nv++; v_cyc = cyc; v_data = cpu_rd_data; end
    end
    total++;
    if (wr_slot < 0 || rd_slot <= wr_slot) begin
      bad++; $display("FAIL wr_rd_order wr_slot=%0d rd_slot=%0d want rd after wr", wr_slot, rd_slot);
    end
    total++;
    if (nv != 1 || v_cyc != rd_slot + 2 || v_data !== 8'h5A) begin
      bad++; $display("FAIL wr_rd_data pulses=%0d at=%0d data=%h want 1 at %0d data 5a",
                      nv, v_cyc, v_data, rd_slot + 2);
    end
  endtask

  task automatic test_busy_ignore();
    int nv = 0, saw_b = 0;
    logic [7:0] v_data = '0;
    ce_pix = 1; cpu_rd_req = 1; cpu_rd_addr = 23'h0500;
    settle(); advance();
    cpu_rd_addr = 23'h0501;
    total++;
    if (cpu_rd_busy !== 1'b1) begin bad++; $display("FAIL busy_set got=%b want=1", cpu_rd_busy); end
    settle(); advance();
    cpu_rd_req = 0; ce_pix = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (ram_addr == 23'h0501) saw_b++;
      advance();
      if (cpu_rd_valid) begin nv++; v_data = cpu_rd_data; end
    end
    total++;
    if (nv != 1 || v_data !== 8'h3C || saw_b != 0 || cpu_rd_busy !== 1'b0) begin
      bad++; $display("FAIL busy_ignore pulses=%0d data=%h second_issued=%0d busy=%b want 1/3c/0/0",
                      nv, v_data, saw_b, cpu_rd_busy);
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    set_idle(); stall_clr = 1; settle(); advance(); stall_clr = 0;
    ce_pix = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_wr_req = 1; cpu_wr_addr = 23'h0800 + ADDR_W'(i); cpu_wr_data = 8'(i);
      settle(); advance();
    end
    cpu_wr_addr = 23'h0804;
    for (int i = 0; i < 10; i++) begin settle(); advance(); end
    total++;
    if (stall_count !== 16'd10 || stall_count !== e_stall) begin
      bad++; $display("FAIL stall_count got=%0d want=10", stall_count);
    end
    stall_clr = 1; settle(); advance(); stall_clr = 0;
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("FAIL stall_clr got=%0d want=0", stall_count); end
    set_idle();
    for (int i = 0; i < 5; i++) begin settle(); advance(); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ce_pix      = ($urandom_range(0, 9) < 6);
      vid_addr    = 23'h0700 + ADDR_W'($urandom_range(0, 15));
      cpu_wr_req  = ($urandom_range(0, 9) < 4);
      cpu_wr_addr = 23'h0700 + ADDR_W'($urandom_range(0, 15));
      cpu_wr_data = 8'($urandom);
      cpu_rd_req  = ($urandom_range(0, 9) < 2);
      cpu_rd_addr = 23'h0700 + ADDR_W'($urandom_range(0, 15));
`ifdef ARB_STATS_EN
      stall_clr   = ($urandom_range(0, 49) == 0);
`endif
      settle();
      total++;
      if (ram_we !== e_we || ram_addr !== e_addr || (e_we && ram_wdata !== e_wdata)) begin
        bad++; $display("FAIL rand_slot cyc=%0d we=%b addr=%h wd=%h want %b/%h/%h",
                        cyc, ram_we, ram_addr, ram_wdata, e_we, e_addr, e_wdata);
      end
      advance();
      total++;
      if (vid_data !== e_vid || fifo_full !== e_full || cpu_rd_busy !== e_busy ||
          cpu_rd_valid !== e_valid || cpu_rd_data !== e_rd_data) begin
        bad++; $display("FAIL rand_regs cyc=%0d vid=%h full=%b busy=%b val=%b rd=%h want %h/%b/%b/%b/%h",
                        cyc, vid_data, fifo_full, cpu_rd_busy, cpu_rd_valid, cpu_rd_data,
                        e_vid, e_full, e_busy, e_valid, e_rd_data);
      end
`ifdef ARB_STATS_EN
      total++;
      if (stall_count !== e_stall) begin
        bad++; $display("FAIL rand_stall cyc=%0d got=%0d want=%0d", cyc, stall_count, e_stall);
      end
`endif
    end
    set_idle();
    for (int i = 0; i < 12; i++) begin settle(); advance(); end
  endtask

  task automatic test_reset_midop();
    ce_pix = 1; cpu_wr_req = 1; cpu_wr_addr = 23'h0600; cpu_wr_data = 8'h77;
    cpu_rd_req = 1; cpu_rd_addr = 23'h0502;
    settle(); advance();
    set_idle();
    settle(); advance();
    cpu_wr_req = 1; cpu_wr_addr = 23'h0601; cpu_wr_data = 8'h88;
    settle();
    total++;
    if (ram_addr !== 23'h0502 || ram_we !== 1'b0) begin
      bad++; $display("FAIL midop_rd_slot addr=%h we=%b want 0502/0", ram_addr, ram_we);
    end
    advance();
    reset_n = 0; #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ram_we !== 1'b0 || cpu_rd_valid !== 1'b0 || cpu_rd_busy !== 1'b0 || fifo_full !== 1'b0 ||
          vid_data !== 8'h00 || cpu_rd_data !== 8'h00) begin
        bad++; $display("FAIL midop_reset step=%0d we=%b val=%b busy=%b full=%b vid=%h rd=%h want 0",
                        i, ram_we, cpu_rd_valid, cpu_rd_busy, fifo_full, vid_data, cpu_rd_data);
      end
      @(posedge clk_vid); @(negedge clk_vid); #1;
    end
    reset_n = 1; set_idle(); reset_model();
    ce_pix = 1; vid_addr = 23'h12000;
    settle(); advance();
    ce_pix = 0;
    settle();
    total++;
    if (ram_we !== 1'b0) begin bad++; $display("FAIL midop_fifo_empty we=%b want=0", ram_we); end
    advance();
    total++;
    if (vid_data !== 8'hA5 || cpu_rd_valid !== 1'b0 || fifo_full !== 1'b0) begin
      bad++; $display("FAIL midop_refetch vid=%h val=%b full=%b want a5/0/0",
                      vid_data, cpu_rd_valid, fifo_full);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) m_mem[i] = ram_init(i);
    reset_model();
    test_reset();
    test_video();
    test_write_burst();
    test_write_then_read();
    test_busy_ignore();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
